// File: rtl/noc_packetizer_pkg.sv
// Shared types and flit field layout for the NoC packetizer.
// Head flit carries destination, source and payload length.
package noc_packetizer_pkg;

  localparam int ARRAY_W   = 2;
  localparam int ENTRY_W   = 32;
  localparam int VCH_W     = 1;
  localparam int VCH_NUM   = 2;
  localparam int BUF_DEPTH = 4;
  localparam int MAX_LEN   = 15;
  localparam int LEN_W     = $clog2(MAX_LEN + 1);
  localparam int CRD_W     = $clog2(BUF_DEPTH + 1);

  localparam int FTYPE_W = 2;
  localparam logic [FTYPE_W-1:0] FT_HEAD     = 2'd0;
  localparam logic [FTYPE_W-1:0] FT_BODY     = 2'd1;
  localparam logic [FTYPE_W-1:0] FT_TAIL     = 2'd2;
  localparam logic [FTYPE_W-1:0] FT_HEADTAIL = 2'd3;

  localparam int DSTX_LSB = 0;
  localparam int DSTX_MSB = DSTX_LSB + ARRAY_W - 1;
  localparam int DSTY_LSB = DSTX_MSB + 1;
  localparam int DSTY_MSB = DSTY_LSB + ARRAY_W - 1;
  localparam int SRCX_LSB = DSTY_MSB + 1;
  localparam int SRCX_MSB = SRCX_LSB + ARRAY_W - 1;
  localparam int SRCY_LSB = SRCX_MSB + 1;
  localparam int SRCY_MSB = SRCY_LSB + ARRAY_W - 1;
  localparam int LEN_LSB  = SRCY_MSB + 1;
  localparam int LEN_MSB  = LEN_LSB + LEN_W - 1;

  typedef enum logic [1:0] {
    PKT_IDLE,
    PKT_HEAD,
    PKT_BODY
  } pkt_state_e;

  function automatic logic [ENTRY_W-1:0] head_flit(
    input logic [ARRAY_W-1:0] dx,
    input logic [ARRAY_W-1:0] dy,
    input logic [ARRAY_W-1:0] sx,
    input logic [ARRAY_W-1:0] sy,
    input logic [LEN_W-1:0]   len
  );
    logic [ENTRY_W-1:0] f;
    f = '0;
    f[DSTX_MSB:DSTX_LSB] = dx;
    f[DSTY_MSB:DSTY_LSB] = dy;
    f[SRCX_MSB:SRCX_LSB] = sx;
    f[SRCY_MSB:SRCY_LSB] = sy;
    f[LEN_MSB:LEN_LSB]   = len;
    return f;
  endfunction

endpackage

// File: rtl/noc_packetizer_if.sv
// Request, payload, flit and credit signals between a
// message source and the packetizer.
interface noc_packetizer_if
  import noc_packetizer_pkg::*;
();

  logic               req_valid;
  logic               req_ready;
  logic [ARRAY_W-1:0] req_dstx;
  logic [ARRAY_W-1:0] req_dsty;
  logic [VCH_W-1:0]   req_vch;
  logic [LEN_W-1:0]   req_len;

  logic               pl_valid;
  logic               pl_ready;
  logic [ENTRY_W-1:0] pl_data;

  logic               send;
  logic [ENTRY_W-1:0] flit;
  logic [FTYPE_W-1:0] ftype;
  logic [VCH_W-1:0]   vch;
  logic [VCH_NUM-1:0] credit;

  modport master (
    output req_valid, req_dstx, req_dsty,
    output req_vch, req_len,
    output pl_valid, pl_data, credit,
    input  req_ready, pl_ready,
    input  send, flit, ftype, vch
  );

  modport slave (
    input  req_valid, req_dstx, req_dsty,
    input  req_vch, req_len,
    input  pl_valid, pl_data, credit,
    output req_ready, pl_ready,
    output send, flit, ftype, vch
  );

endinterface

// File: rtl/noc_packetizer_credit_cnt.sv
// Per-VC credit counter toward the router input buffer.
// Starts full, saturates at full and flags an overflow.
module noc_credit_cnt
  import noc_packetizer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CRD_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CRD_W-1:0] FULL = CRD_W'(BUF_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= FULL;
      ovf <= 1'b0;
    end else if (inc && !dec) begin
      if (cnt == FULL) ovf <= 1'b1;
      else cnt <= cnt + 1'b1;
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/noc_packetizer.sv
// Network-interface injector: request + payload stream in,
// head/body/tail flits out under per-VC credit control.
module noc_packetizer
  import noc_packetizer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ARRAY_W-1:0] xpos,
  input  logic [ARRAY_W-1:0] ypos,
  noc_packetizer_if.slave    bus,
  output logic               err
);

  pkt_state_e state;

  logic [ARRAY_W-1:0] dstx;
  logic [ARRAY_W-1:0] dsty;
  logic [VCH_W-1:0]   pvch;
  logic [LEN_W-1:0]   plen;
  logic [LEN_W-1:0]   rem;

  logic               send_q;
  logic [ENTRY_W-1:0] flit_q;
  logic [FTYPE_W-1:0] ftype_q;
  logic [VCH_W-1:0]   vch_q;

  logic [CRD_W-1:0]   cnt [VCH_NUM];
  logic [VCH_NUM-1:0] ovf;
  logic [VCH_NUM-1:0] dec;

  logic has_crd;
  logic head_fire;
  logic body_fire;

  assign has_crd   = cnt[pvch] != '0;
  assign head_fire = (state == PKT_HEAD) && has_crd;
  assign body_fire = bus.pl_valid && bus.pl_ready;

  assign bus.req_ready = state == PKT_IDLE;
  assign bus.pl_ready  = (state == PKT_BODY) && has_crd;
  assign bus.send      = send_q;
  assign bus.flit      = flit_q;
  assign bus.ftype     = ftype_q;
  assign bus.vch       = vch_q;
  assign err           = |ovf;

  always_comb begin
    dec       = '0;
    dec[pvch] = head_fire || body_fire;
  end

  for (genvar v = 0; v < VCH_NUM; v++) begin : g_crd
    noc_credit_cnt u_crd (
      .clk (clk),
      .rst (rst),
      .inc (bus.credit[v]),
      .dec (dec[v]),
      .cnt (cnt[v]),
      .ovf (ovf[v])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PKT_IDLE;
      dstx    <= '0;
      dsty    <= '0;
      pvch    <= '0;
      plen    <= '0;
      rem     <= '0;
      send_q  <= 1'b0;
      flit_q  <= '0;
      ftype_q <= '0;
      vch_q   <= '0;
    end else begin
      send_q <= 1'b0;
      unique case (state)
        PKT_IDLE: begin
          if (bus.req_valid) begin
            dstx  <= bus.req_dstx;
            dsty  <= bus.req_dsty;
            pvch  <= bus.req_vch;
            plen  <= (int'(bus.req_len) > MAX_LEN)
                   ? LEN_W'(MAX_LEN) : bus.req_len;
            state <= PKT_HEAD;
          end
        end
        PKT_HEAD: begin
          if (has_crd) begin
            send_q  <= 1'b1;
            flit_q  <= head_flit(dstx, dsty, xpos, ypos, plen);
            ftype_q <= (plen == '0) ? FT_HEADTAIL : FT_HEAD;
            vch_q   <= pvch;
            rem     <= plen;
            state   <= (plen == '0) ? PKT_IDLE : PKT_BODY;
          end
        end
        PKT_BODY: begin
          if (body_fire) begin
            send_q  <= 1'b1;
            flit_q  <= bus.pl_data;
            ftype_q <= (rem == LEN_W'(1)) ? FT_TAIL : FT_BODY;
            vch_q   <= pvch;
            rem     <= rem - 1'b1;
            if (rem == LEN_W'(1)) state <= PKT_IDLE;
          end
        end
        default: state <= PKT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_packetizer.sv
// Bench for noc_packetizer: directed scenarios plus random
// traffic checked against a flit scoreboard and credit model.
module tb_noc_packetizer;
  import noc_packetizer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [ARRAY_W-1:0] xpos;
  logic [ARRAY_W-1:0] ypos;
  logic err;

  noc_packetizer_if bus ();

  noc_packetizer dut (
    .clk  (clk),
    .rst  (rst),
    .xpos (xpos),
    .ypos (ypos),
    .bus  (bus.slave),
    .err  (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ENTRY_W-1:0] flit;
    logic [FTYPE_W-1:0] ftype;
    logic [VCH_W-1:0]   vch;
  } exp_t;

  exp_t expq[$];
  exp_t me;
  int sent  [VCH_NUM] = '{default: 0};
  int ret   [VCH_NUM] = '{default: 0};
  int avail [VCH_NUM] = '{default: BUF_DEPTH};
  int pend_len = 0;
  int nbody = 0;
  int mlen;
  logic [VCH_W-1:0] cur_vch = '0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Scoreboard and credit model, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.send === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got flit %0h expected none",
                 bus.flit);
      end else begin
        me = expq.pop_front();
        check("sb_flit", bus.flit, me.flit);
        check("sb_ftype", 32'(bus.ftype), 32'(me.ftype));
        check("sb_vch", 32'(bus.vch), 32'(me.vch));
      end
      sent[bus.vch]++;
      avail[bus.vch]--;
      check("credit_nonneg", 32'(avail[bus.vch] >= 0), 32'd1);
    end
    if (bus.pl_ready === 1'b1)
      check("pl_ready_credit", 32'(avail[cur_vch] > 0), 32'd1);
    if (rst !== 1'b0) begin
      expq.delete();
      for (int v = 0; v < VCH_NUM; v++) begin
        sent[v]  = 0;
        ret[v]   = 0;
        avail[v] = BUF_DEPTH;
      end
      pend_len = 0;
      nbody    = 0;
    end else begin
      check("ready_excl",
            32'(bus.req_ready && bus.pl_ready), 32'd0);
      for (int v = 0; v < VCH_NUM; v++)
        if (bus.credit[v]) begin
          ret[v]++;
          avail[v]++;
        end
      if (bus.req_valid && bus.req_ready) begin
        mlen = (int'(bus.req_len) > MAX_LEN)
             ? MAX_LEN : int'(bus.req_len);
        me.flit = (ENTRY_W'(bus.req_dstx) << DSTX_LSB)
                | (ENTRY_W'(bus.req_dsty) << DSTY_LSB)
                | (ENTRY_W'(xpos) << SRCX_LSB)
                | (ENTRY_W'(ypos) << SRCY_LSB)
                | (ENTRY_W'(mlen) << LEN_LSB);
        me.ftype = (mlen == 0) ? FT_HEADTAIL : FT_HEAD;
        me.vch   = bus.req_vch;
        expq.push_back(me);
        cur_vch  = bus.req_vch;
        pend_len = mlen;
        nbody    = 0;
      end
      if (bus.pl_valid && bus.pl_ready) begin
        nbody++;
        if (nbody > pend_len) begin
          checks++;
          errors++;
          $display("FAIL extra_payload: got %0d expected %0d",
                   nbody, pend_len);
        end
        me.flit  = bus.pl_data;
        me.ftype = (nbody == pend_len) ? FT_TAIL : FT_BODY;
        me.vch   = cur_vch;
        expq.push_back(me);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int dx, input int dy,
                         input int v, input int len);
    bus.req_valid = 1'b1;
    bus.req_dstx  = ARRAY_W'(dx);
    bus.req_dsty  = ARRAY_W'(dy);
    bus.req_vch   = VCH_W'(v);
    bus.req_len   = LEN_W'(len);
  endtask

  task automatic pulse(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      bus.credit    = '0;
      bus.credit[v] = 1'b1;
      tick();
    end
    bus.credit = '0;
  endtask

  initial begin
    int cnt;
    int pkts;
    logic acc;
    logic first;
    logic [FTYPE_W-1:0] lastft;
    logic [VCH_NUM-1:0] c;

    rst           = 1'b1;
    xpos          = 2'd1;
    ypos          = 2'd1;
    bus.req_valid = 1'b0;
    bus.req_dstx  = '0;
    bus.req_dsty  = '0;
    bus.req_vch   = '0;
    bus.req_len   = '0;
    bus.pl_valid  = 1'b0;
    bus.pl_data   = '0;
    bus.credit    = '0;
    lastft        = '0;
    repeat (3) tick();
    check("rst_send", 32'(bus.send), 32'd0);
    check("rst_flit", bus.flit, 32'd0);
    check("rst_ftype", 32'(bus.ftype), 32'd0);
    check("rst_vch", 32'(bus.vch), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_pl_ready", 32'(bus.pl_ready), 32'd0);
    rst = 1'b0;

    // dst(3,2) vch1 len2 from node (1,1)
    set_req(3, 2, 1, 2);
    tick();
    bus.req_valid = 1'b0;
    check("a_t1_send", 32'(bus.send), 32'd0);
    check("a_busy", 32'(bus.req_ready), 32'd0);
    bus.pl_valid = 1'b1;
    bus.pl_data  = 32'hA;
    tick();
    check("a_head_send", 32'(bus.send), 32'd1);
    check("a_head_flit", bus.flit, 32'h25B);
    check("a_head_type", 32'(bus.ftype), 32'(FT_HEAD));
    check("a_head_vch", 32'(bus.vch), 32'd1);
    check("a_pl_ready", 32'(bus.pl_ready), 32'd1);
    tick();
    bus.pl_data = 32'hB;
    check("a_body_flit", bus.flit, 32'hA);
    check("a_body_type", 32'(bus.ftype), 32'(FT_BODY));
    tick();
    bus.pl_valid = 1'b0;
    check("a_tail_flit", bus.flit, 32'hB);
    check("a_tail_type", 32'(bus.ftype), 32'(FT_TAIL));
    check("a_idle", 32'(bus.req_ready), 32'd1);

    // len 0 to (0,0) on vch0
    set_req(0, 0, 0, 0);
    tick();
    bus.req_valid = 1'b0;
    check("b_send_one_cycle", 32'(bus.send), 32'd0);
    tick();
    check("b_ht_send", 32'(bus.send), 32'd1);
    check("b_ht_flit", bus.flit, 32'h50);
    check("b_ht_type", 32'(bus.ftype), 32'(FT_HEADTAIL));
    check("b_ready_next", 32'(bus.req_ready), 32'd1);

    // len 6 on vch0 with a full credit window, then starved
    set_req(2, 1, 0, 6);
    bus.credit   = 2'b01;
    bus.pl_valid = 1'b1;
    bus.pl_data  = 32'h100;
    tick();
    bus.req_valid = 1'b0;
    bus.credit    = '0;
    check("b_accepted", 32'(bus.req_ready), 32'd0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      bus.pl_data = bus.pl_data + 1;
      tick();
      cnt += int'(bus.send);
    end
    check("c_burst", 32'(cnt), 32'd4);
    check("c_stalled", 32'(bus.pl_ready), 32'd0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      bus.pl_data = bus.pl_data + 1;
      bus.credit  = (i < 2) ? 2'b01 : 2'b00;
      tick();
      cnt += int'(bus.send);
    end
    check("c_resume2", 32'(cnt), 32'd2);
    check("c_resume2_type", 32'(bus.ftype), 32'(FT_BODY));
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      bus.pl_data = bus.pl_data + 1;
      bus.credit  = (i < 1) ? 2'b01 : 2'b00;
      tick();
      cnt += int'(bus.send);
    end
    bus.pl_valid = 1'b0;
    bus.credit   = '0;
    check("c_resume1", 32'(cnt), 32'd1);
    check("c_tail_type", 32'(bus.ftype), 32'(FT_TAIL));
    check("c_idle", 32'(bus.req_ready), 32'd1);
    pulse(0, 4);

    // toggling payload valid, len 4 on vch0
    set_req(1, 3, 0, 4);
    tick();
    bus.req_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      bus.pl_valid = (i % 2) == 1;
      bus.pl_data  = $urandom;
      bus.credit   = (i >= 6 && i <= 9) ? 2'b01 : 2'b00;
      tick();
      cnt += int'(bus.send);
      if (bus.send) lastft = bus.ftype;
    end
    bus.pl_valid = 1'b0;
    bus.credit   = '0;
    check("e_count", 32'(cnt), 32'd5);
    check("e_last_tail", 32'(lastft), 32'(FT_TAIL));

    // credit with send on the same VC, then overflow
    pulse(1, 3);
    check("d_pre_err", 32'(err), 32'd0);
    set_req(0, 1, 1, 0);
    tick();
    bus.req_valid = 1'b0;
    bus.credit    = 2'b10;
    tick();
    bus.credit = '0;
    check("d_same_send", 32'(bus.send), 32'd1);
    check("d_same_no_err", 32'(err), 32'd0);
    bus.credit = 2'b10;
    tick();
    bus.credit = '0;
    check("d_overflow", 32'(err), 32'd1);
    repeat (3) tick();
    check("d_sticky", 32'(err), 32'd1);

    // reset in the middle of a body
    set_req(3, 3, 0, 5);
    bus.pl_valid = 1'b1;
    bus.pl_data  = $urandom;
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.pl_data = $urandom;
    tick();
    rst = 1'b1;
    tick();
    check("f_send", 32'(bus.send), 32'd0);
    check("f_flit", bus.flit, 32'd0);
    check("f_ftype", 32'(bus.ftype), 32'd0);
    check("f_err", 32'(err), 32'd0);
    check("f_idle", 32'(bus.req_ready), 32'd1);
    check("f_pl_ready", 32'(bus.pl_ready), 32'd0);
    rst = 1'b0;
    set_req(2, 3, 0, 3);
    cnt   = 0;
    first = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.pl_data = $urandom;
      tick();
      bus.req_valid = 1'b0;
      if (bus.send && first) begin
        check("f_new_head", bus.flit, 32'h35E);
        first = 1'b0;
      end
      cnt += int'(bus.send);
    end
    bus.pl_valid = 1'b0;
    check("f_full_credit", 32'(cnt), 32'd4);

    // random traffic
    pkts = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      c = '0;
      for (int v = 0; v < VCH_NUM; v++)
        if (sent[v] - ret[v] > 0 && $urandom_range(2) == 0)
          c[v] = 1'b1;
      bus.credit   = c;
      bus.pl_valid = $urandom_range(3) != 0;
      bus.pl_data  = $urandom;
      if (!bus.req_valid && pkts < 60 && $urandom_range(3) == 0)
        set_req(int'($urandom_range(3)), int'($urandom_range(3)),
                int'($urandom_range(1)),
                int'($urandom_range(MAX_LEN)));
      acc = bus.req_valid && bus.req_ready;
      tick();
      if (acc) begin
        bus.req_valid = 1'b0;
        pkts++;
      end
      if (pkts == 60 && bus.req_ready && !bus.req_valid &&
          expq.size() == 0)
        break;
    end
    bus.credit   = '0;
    bus.pl_valid = 1'b0;
    repeat (3) tick();
    check("rnd_pkts", 32'(pkts), 32'd60);
    check("rnd_drained", 32'(expq.size()), 32'd0);
    check("rnd_no_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
